// File: rtl/window_pkg.sv
// Shared types and constants for the CNN window fetcher: FSM states and the
// hard-wired 3x3 slot-to-offset map feeding the conv/ReLu/pool ALU.
package window_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_F,
    FETCH,
    HOLD,
    DONE
  } state_t;

  localparam int unsigned NSLOT          = 10;
  localparam int unsigned NTAP           = 9;
  localparam int unsigned SLOT_POOL_COPY = 4;
  localparam int unsigned RC_W           = 5;

  // Row/column offset of each fetched slot relative to the window top-left.
  localparam logic [1:0] DR [9] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
  localparam logic [1:0] DC [9] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

  function automatic logic [1:0] slot_dr(input logic [3:0] k);
    return (k < 4'd9) ? DR[k] : 2'd0;
  endfunction

  function automatic logic [1:0] slot_dc(input logic [3:0] k);
    return (k < 4'd9) ? DC[k] : 2'd0;
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Window position counters (raster order, stride 1) and image address
// generation for a given slot of the current or next window.
module window_addr_gen
  import window_pkg::*;
#(
  parameter int unsigned M_AW = 10,
  parameter int unsigned IMG  = 28,
  parameter int unsigned FIL  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            advance,
  input  logic [3:0]      slot,
  output logic [RC_W-1:0] row,
  output logic [RC_W-1:0] col,
  output logic            last,
  output logic [M_AW-1:0] addr
);

  localparam logic [RC_W-1:0] LIM = RC_W'(IMG - FIL);

  logic [RC_W-1:0] nrow, ncol, brow, bcol;

  always_comb begin
    if (col == LIM) begin
      ncol = '0;
      nrow = row + RC_W'(1);
    end else begin
      ncol = col + RC_W'(1);
      nrow = row;
    end
    // While advancing, the address is taken from the next window so its
    // first slot can be issued on the same edge the counters move.
    brow = advance ? nrow : row;
    bcol = advance ? ncol : col;
    addr = (M_AW'(brow) + M_AW'(slot_dr(slot))) * M_AW'(IMG)
         + M_AW'(bcol) + M_AW'(slot_dc(slot));
    last = (row == LIM) && (col == LIM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      row <= nrow;
      col <= ncol;
    end
  end

endmodule

// File: rtl/window_fetch.sv
// Loads the 3x3 filter, then raster-scans the image and presents one
// 10-slot pixel vector plus 9 filter taps per window over valid/ready.
module window_fetch
  import window_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned M_AW = 10,
  parameter int unsigned F_AW = 4,
  parameter int unsigned FIL  = 3,
  parameter int unsigned IMG  = 28,
  parameter int unsigned IOUT = 10 * N,
  parameter int unsigned FOUT = 9 * N
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            img_rd_en,
  output logic [M_AW-1:0] img_addr,
  input  logic [N-1:0]    img_rdata,
  output logic            fil_rd_en,
  output logic [F_AW-1:0] fil_addr,
  input  logic [N-1:0]    fil_rdata,
  output logic [IOUT-1:0] I_out,
  output logic [FOUT-1:0] F_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      win_row,
  output logic [4:0]      win_col,
  output logic            busy,
  output logic            done
);

  localparam logic [3:0] LAST_IDX = 4'(NTAP - 1);

  state_t          state;
  logic [3:0]      issue_idx;
  logic [3:0]      cap_idx;
  logic            cap_en;
  logic            ag_clear;
  logic            ag_advance;
  logic            ag_last;
  logic [3:0]      slot_sel;
  logic [M_AW-1:0] ag_addr;

  window_addr_gen #(
    .M_AW (M_AW),
    .IMG  (IMG),
    .FIL  (FIL)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (ag_clear),
    .advance (ag_advance),
    .slot    (slot_sel),
    .row     (win_row),
    .col     (win_col),
    .last    (ag_last),
    .addr    (ag_addr)
  );

  always_comb begin
    ag_clear   = (state == IDLE) && start;
    ag_advance = (state == HOLD) && out_ready && !ag_last;
    slot_sel   = '0;
    if ((state == FETCH) && img_rd_en && (issue_idx != LAST_IDX))
      slot_sel = issue_idx + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      img_rd_en <= 1'b0;
      img_addr  <= '0;
      fil_rd_en <= 1'b0;
      fil_addr  <= '0;
      I_out     <= '0;
      F_out     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      issue_idx <= '0;
      cap_idx   <= '0;
      cap_en    <= 1'b0;
    end else begin
      done   <= 1'b0;
      cap_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD_F;
            busy      <= 1'b1;
            fil_rd_en <= 1'b1;
            fil_addr  <= '0;
          end
        end
        LOAD_F: begin
          cap_en  <= fil_rd_en;
          cap_idx <= 4'(fil_addr);
          if (fil_rd_en) begin
            if (fil_addr == F_AW'(NTAP - 1)) fil_rd_en <= 1'b0;
            else                              fil_addr  <= fil_addr + F_AW'(1);
          end
          if (cap_en) begin
            F_out[cap_idx * N +: N] <= fil_rdata;
            if (cap_idx == LAST_IDX) begin
              state     <= FETCH;
              img_rd_en <= 1'b1;
              img_addr  <= ag_addr;
              issue_idx <= '0;
            end
          end
        end
        FETCH: begin
          cap_en  <= img_rd_en;
          cap_idx <= issue_idx;
          if (img_rd_en) begin
            if (issue_idx == LAST_IDX) begin
              img_rd_en <= 1'b0;
            end else begin
              issue_idx <= issue_idx + 4'd1;
              img_addr  <= ag_addr;
            end
          end
          if (cap_en) begin
            I_out[cap_idx * N +: N] <= img_rdata;
            if (cap_idx == 4'(SLOT_POOL_COPY))
              I_out[(NSLOT - 1) * N +: N] <= img_rdata;
            if (cap_idx == LAST_IDX) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (ag_last) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state     <= FETCH;
              img_rd_en <= 1'b1;
              img_addr  <= ag_addr;
              issue_idx <= '0;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_fetch.sv
// Bench for window_fetch: memory models plus a raster/slot-map reference model.
module tb_window_fetch;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        img_rd_en;
  logic [9:0]  img_addr;
  logic [7:0]  img_rdata;
  logic        fil_rd_en;
  logic [3:0]  fil_addr;
  logic [7:0]  fil_rdata;
  logic [79:0] I_out;
  logic [71:0] F_out;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  win_row;
  logic [4:0]  win_col;
  logic        busy;
  logic        done;

  window_fetch #(
    .N    (8),
    .M_AW (10),
    .F_AW (4),
    .FIL  (3),
    .IMG  (28),
    .IOUT (80),
    .FOUT (72)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .img_rd_en (img_rd_en),
    .img_addr  (img_addr),
    .img_rdata (img_rdata),
    .fil_rd_en (fil_rd_en),
    .fil_addr  (fil_addr),
    .fil_rdata (fil_rdata),
    .I_out     (I_out),
    .F_out     (F_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .win_row   (win_row),
    .win_col   (win_col),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] img_mem [784];
  logic [7:0] fil_mem [9];

  // Synchronous-read memories; junk is returned whenever no read was issued.
  always @(posedge clk) begin
    if (img_rd_en && img_addr < 10'd784) img_rdata <= img_mem[img_addr];
    else                                 img_rdata <= 8'($urandom);
    if (fil_rd_en && fil_addr < 4'd9)    fil_rdata <= fil_mem[fil_addr];
    else                                 fil_rdata <= 8'($urandom);
  end

  int errors;
  int checks;
  int hs_count;

  int dr_t [10] = '{0, 0, 1, 0, 1, 1, 2, 2, 2, 1};
  int dc_t [10] = '{0, 1, 0, 2, 1, 2, 0, 1, 2, 1};
  int first_slots [10] = '{0, 1, 28, 2, 29, 30, 56, 57, 58, 29};

  function automatic logic [79:0] exp_iout(input int r, input int c);
    logic [79:0] v;
    for (int k = 0; k < 10; k++)
      v[k*8 +: 8] = img_mem[(r + dr_t[k]) * 28 + c + dc_t[k]];
    return v;
  endfunction

  function automatic logic [71:0] exp_fout();
    logic [71:0] v;
    for (int k = 0; k < 9; k++) v[k*8 +: 8] = fil_mem[k];
    return v;
  endfunction

  task automatic load_pattern(input bit rnd);
    for (int i = 0; i < 784; i++) img_mem[i] = rnd ? 8'($urandom) : 8'(i);
    for (int k = 0; k < 9; k++)   fil_mem[k] = rnd ? 8'($urandom) : 8'(16 + k);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, busy, done, img_rd_en, fil_rd_en} !== 5'b0 || I_out !== '0 || F_out !== '0 ||
        img_addr !== '0 || fil_addr !== '0 || win_row !== '0 || win_col !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b img_rd=%b fil_rd=%b I_out=%h F_out=%h row=%0d col=%0d, want all 0",
               out_valid, busy, done, img_rd_en, fil_rd_en, I_out, F_out, win_row, win_col);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fil_rd_en !== 1'b0 || img_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: busy=%b fil_rd=%b img_rd=%b, want 0 0 0", busy, fil_rd_en, img_rd_en);
    end
  endtask

  task automatic test_first_window;
    int lat = 0, nf = 0, ni = 0, both = 0;
    logic [79:0] want_i;
    logic [71:0] want_f;
    out_ready = 1'b0;
    hs_count = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!out_valid && lat < 100) begin
      if (fil_rd_en) nf++;
      if (img_rd_en) ni++;
      if (fil_rd_en && img_rd_en) both++;
      @(negedge clk);
      lat++;
    end
    for (int k = 0; k < 10; k++) want_i[k*8 +: 8] = 8'(first_slots[k]);
    for (int k = 0; k < 9; k++)  want_f[k*8 +: 8] = 8'(16 + k);
    checks++;
    if (lat !== 20) begin errors++; $display("FAIL first_latency: got %0d cycles, want 20", lat); end
    checks++;
    if (nf !== 9 || ni !== 9 || both !== 0) begin
      errors++;
      $display("FAIL first_reads: fil_rd=%0d img_rd=%0d overlap=%0d, want 9 9 0", nf, ni, both);
    end
    checks++;
    if (I_out !== want_i) begin errors++; $display("FAIL first_I_out: got %h want %h", I_out, want_i); end
    checks++;
    if (F_out !== want_f) begin errors++; $display("FAIL first_F_out: got %h want %h", F_out, want_f); end
    checks++;
    if (win_row !== 5'd0 || win_col !== 5'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_pos: row=%0d col=%0d busy=%b, want 0 0 1", win_row, win_col, busy);
    end
  endtask

  task automatic test_stall;
    int cyc = 0, r, c;
    bit stalled = 0;
    logic [79:0] snap;
    logic [4:0]  snap_col;
    out_ready = 1'b1;
    while (hs_count < 4 && cyc < 300) begin
      if (out_valid) begin
        r = hs_count / 26; c = hs_count % 26;
        if (r == 0 && c == 3 && !stalled) begin
          out_ready = 1'b0; snap = I_out; snap_col = win_col;
          for (int i = 0; i < 5; i++) begin
            @(negedge clk); cyc++;
            checks++;
            if (I_out !== snap || win_col !== snap_col || out_valid !== 1'b1 || img_rd_en !== 1'b0) begin
              errors++;
              $display("FAIL stall_hold: cycle %0d I_out=%h col=%0d valid=%b img_rd=%b, want I_out=%h col=%0d valid=1 img_rd=0",
                       i, I_out, win_col, out_valid, img_rd_en, snap, snap_col);
            end
          end
          out_ready = 1'b1; stalled = 1;
        end
        checks++;
        if (I_out !== exp_iout(r, c) || F_out !== exp_fout() || win_row !== 5'(r) || win_col !== 5'(c)) begin
          errors++;
          $display("FAIL window_%0d: got row=%0d col=%0d I_out=%h F_out=%h, want row=%0d col=%0d I_out=%h F_out=%h",
                   hs_count, win_row, win_col, I_out, F_out, r, c, exp_iout(r, c), exp_fout());
        end
        hs_count++;
        @(negedge clk); cyc++;
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL handshake_drop: window %0d valid=%b after handshake, want 0", hs_count - 1, out_valid);
        end
      end else begin
        @(negedge clk); cyc++;
      end
    end
    checks++;
    if (hs_count !== 4 || !stalled) begin
      errors++;
      $display("FAIL stall_progress: handshakes=%0d stalled=%0d, want 4 1", hs_count, stalled);
    end
  endtask

  task automatic test_start_ignored;
    int cyc = 0, nf = 0, r, c;
    bit pulsed = 0;
    out_ready = 1'b1;
    while (hs_count < 8 && cyc < 300) begin
      start = 1'b0;
      if (fil_rd_en) nf++;
      if (out_valid) begin
        r = hs_count / 26; c = hs_count % 26;
        checks++;
        if (I_out !== exp_iout(r, c) || F_out !== exp_fout() || win_row !== 5'(r) || win_col !== 5'(c)) begin
          errors++;
          $display("FAIL window_%0d: got row=%0d col=%0d I_out=%h F_out=%h, want row=%0d col=%0d I_out=%h F_out=%h",
                   hs_count, win_row, win_col, I_out, F_out, r, c, exp_iout(r, c), exp_fout());
        end
        hs_count++;
      end else if (hs_count == 5 && img_rd_en && !pulsed) begin
        start = 1'b1; pulsed = 1;
      end
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    checks++;
    if (nf !== 0 || !pulsed || hs_count !== 8 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored: fil_rd=%0d pulsed=%0d handshakes=%0d busy=%b, want 0 1 8 1", nf, pulsed, hs_count, busy);
    end
  endtask

  task automatic test_full_frame;
    int cyc = 0, last_v = -1, bad_per = 0, nf = 0, r, c;
    bit done_seen = 0;
    logic [4:0] pr = '0, pc = '0;
    out_ready = 1'b1;
    while (!done_seen && cyc < 9000) begin
      if (fil_rd_en) nf++;
      if (done) begin
        done_seen = 1;
      end else begin
        if (out_valid) begin
          if (last_v >= 0 && cyc - last_v != 11) bad_per++;
          last_v = cyc;
          r = hs_count / 26; c = hs_count % 26;
          checks++;
          if (I_out !== exp_iout(r, c) || F_out !== exp_fout() || win_row !== 5'(r) || win_col !== 5'(c)) begin
            errors++;
            $display("FAIL window_%0d: got row=%0d col=%0d I_out=%h F_out=%h, want row=%0d col=%0d I_out=%h F_out=%h",
                     hs_count, win_row, win_col, I_out, F_out, r, c, exp_iout(r, c), exp_fout());
          end
          if (hs_count == 26) begin
            checks++;
            if (pr !== 5'd0 || pc !== 5'd25 || win_row !== 5'd1 || win_col !== 5'd0) begin
              errors++;
              $display("FAIL row_wrap: (%0d,%0d)->(%0d,%0d), want (0,25)->(1,0)", pr, pc, win_row, win_col);
            end
          end
          if (hs_count == 675) begin
            checks++;
            if (I_out[7:0] !== 8'hD5 || I_out[71:64] !== 8'h0F) begin
              errors++;
              $display("FAIL last_window: slot0=%h slot8=%h, want d5 0f", I_out[7:0], I_out[71:64]);
            end
          end
          pr = win_row; pc = win_col;
          hs_count++;
        end
        @(negedge clk); cyc++;
      end
    end
    checks++;
    if (!done_seen || hs_count !== 676) begin
      errors++;
      $display("FAIL frame_count: done_seen=%0d handshakes=%0d, want 1 676", done_seen, hs_count);
    end
    checks++;
    if (bad_per !== 0 || nf !== 0) begin
      errors++;
      $display("FAIL frame_period: off-period windows=%0d fil_rd cycles=%0d, want 0 0", bad_per, nf);
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_flags: busy=%b valid=%b at done, want 0 0", busy, out_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || win_row !== 5'd25 || win_col !== 5'd25 || I_out[7:0] !== 8'hD5) begin
      errors++;
      $display("FAIL after_done: done=%b row=%0d col=%0d slot0=%h, want 0 25 25 d5", done, win_row, win_col, I_out[7:0]);
    end
  endtask

  task automatic test_reset_mid_fetch;
    int cyc = 0, bad = 0, lat = 0, nf = 0;
    out_ready = 1'b1;
    hs_count = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!(hs_count == 10 && img_rd_en) && cyc < 500) begin
      if (out_valid) hs_count++;
      @(negedge clk); cyc++;
    end
    checks++;
    if (hs_count !== 10 || img_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL reach_window10: handshakes=%0d img_rd=%b, want 10 1", hs_count, img_rd_en);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, done, img_rd_en, fil_rd_en} !== 5'b0 || I_out !== '0 || F_out !== '0 ||
        img_addr !== '0 || fil_addr !== '0 || win_row !== '0 || win_col !== '0) begin
      errors++;
      $display("FAIL reset_mid_fetch: valid=%b busy=%b done=%b img_rd=%b fil_rd=%b I_out=%h row=%0d col=%0d, want all 0",
               out_valid, busy, done, img_rd_en, fil_rd_en, I_out, win_row, win_col);
    end
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (done || busy || out_valid || img_rd_en || fil_rd_en || I_out !== '0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL post_reset_idle: %0d active cycles, want 0", bad); end
    out_ready = 1'b0;
    hs_count = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!out_valid && lat < 100) begin
      if (fil_rd_en) nf++;
      @(negedge clk); lat++;
    end
    checks++;
    if (lat !== 20 || nf !== 9) begin
      errors++;
      $display("FAIL restart: latency=%0d fil_rd=%0d, want 20 9", lat, nf);
    end
    checks++;
    if (I_out !== exp_iout(0, 0) || F_out !== exp_fout() || win_row !== 5'd0 || win_col !== 5'd0) begin
      errors++;
      $display("FAIL restart_window: row=%0d col=%0d I_out=%h F_out=%h, want 0 0 %h %h",
               win_row, win_col, I_out, F_out, exp_iout(0, 0), exp_fout());
    end
  endtask

  task automatic test_random_frame;
    int cyc = 0, unstable = 0, both = 0, r, c;
    bit done_seen = 0, prev_stall = 0;
    logic [79:0] prev_i = '0;
    logic [9:0]  prev_pos = '0;
    rst_n = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load_pattern(1'b1);
    hs_count = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done_seen && cyc < 40000) begin
      if (img_rd_en && fil_rd_en) both++;
      if (done) begin
        done_seen = 1;
      end else begin
        if (prev_stall && (I_out !== prev_i || out_valid !== 1'b1 || {win_row, win_col} !== prev_pos)) unstable++;
        out_ready = ($urandom_range(0, 3) != 0);
        prev_stall = out_valid && !out_ready;
        prev_i = I_out;
        prev_pos = {win_row, win_col};
        if (out_valid && out_ready) begin
          r = hs_count / 26; c = hs_count % 26;
          checks++;
          if (I_out !== exp_iout(r, c) || F_out !== exp_fout() || win_row !== 5'(r) || win_col !== 5'(c)) begin
            errors++;
            $display("FAIL rnd_window_%0d: got row=%0d col=%0d I_out=%h F_out=%h, want row=%0d col=%0d I_out=%h F_out=%h",
                     hs_count, win_row, win_col, I_out, F_out, r, c, exp_iout(r, c), exp_fout());
          end
          hs_count++;
        end
        @(negedge clk); cyc++;
      end
    end
    checks++;
    if (!done_seen || hs_count !== 676) begin
      errors++;
      $display("FAIL rnd_frame_count: done_seen=%0d handshakes=%0d, want 1 676", done_seen, hs_count);
    end
    checks++;
    if (unstable !== 0 || both !== 0) begin
      errors++;
      $display("FAIL rnd_stability: unstable stalls=%0d rd overlap=%0d, want 0 0", unstable, both);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    hs_count = 0;
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    load_pattern(1'b0);
    test_reset;
    test_first_window;
    test_stall;
    test_start_ignored;
    test_full_frame;
    test_reset_mid_fetch;
    test_random_frame;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/window_fetch.md
Name: window_fetch

Overview:
- Upstream feeder for the CNN co-processor ALU stage (conv / ReLu / pool).
- Loads the 3x3 filter once, then raster-scans the IMG x IMG image memory with stride 1.
- For each position, assembles one 10-slot pixel vector I_out plus the 9-tap F_out.
- Presents each vector to the ALU under a valid/ready handshake.

Parameters:
- N, 8: pixel/coefficient data width.
- M_AW, 10: image memory address width.
- F_AW, 4: filter memory address width (9 taps, so 4 bits are required).
- FIL, 3: filter edge size; fixed at 3 (slot map below is hard-wired).
- IMG, 28: image edge size.
- IOUT, 10*N: I_out width.
- FOUT, 9*N: F_out width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a full frame pass when idle.
- img_rd_en  out  1  image memory read strobe.
- img_addr  out  M_AW  image read address.
- img_rdata  in  N  image read data, valid the cycle after img_rd_en.
- fil_rd_en  out  1  filter memory read strobe.
- fil_addr  out  F_AW  filter read address.
- fil_rdata  in  N  filter read data, valid the cycle after fil_rd_en.
- I_out  out  IOUT  window slots to the ALU.
- F_out  out  FOUT  filter taps to the ALU; slot k is at [k*N +: N].
- out_valid  out  1  I_out/F_out hold a complete window.
- out_ready  in  1  ALU accepts the window.
- win_row  out  5  window top-left row.
- win_col  out  5  window top-left column.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last window handshake.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE.
  - All outputs, I_out/F_out registers and counters are cleared to 0.
  - Applies mid-frame as well: any in-flight read data is discarded the next cycle.
- Slot map; (dr,dc) is the offset from (win_row,win_col); slot k is at I_out[k*N +: N]:
  - 0:(0,0)  1:(0,1)  2:(1,0)  3:(0,2)  4:(1,1)
  - 5:(1,2)  6:(2,0)  7:(2,1)  8:(2,2)
  - Slot 9 is a copy of slot 4, so slots {9,2,1,0} form the 2x2 pool quad.
  - Filter address k pairs with slot k.
- Address rule: img_addr = (win_row+dr)*IMG + (win_col+dc), computed unsigned in M_AW bits. The maximum is 783, so there is no overflow.
- FSM states and transitions:
  - IDLE: start=1 -> LOAD_F, busy=1. start is ignored in every other state.
  - LOAD_F: issues fil_addr 0..8 on 9 consecutive cycles, captures each datum one cycle later, then -> FETCH. Total 10 cycles.
  - FETCH: issues img_addr for slots 0..8 on 9 consecutive cycles. Each datum is written to its slot one cycle after issue; slot 9 is written together with slot 4. After the last capture -> HOLD, out_valid=1.
    - Latency from FETCH entry to out_valid = 10 cycles.
  - HOLD: I_out, F_out, win_row and win_col are stable while out_valid=1 and out_ready=0.
    - On out_valid & out_ready: out_valid drops next cycle.
    - Then, if (win_row,win_col)=(IMG-FIL, IMG-FIL): -> DONE.
    - Otherwise advance the column; on col = IMG-FIL wrap col to 0 and increment row; -> FETCH.
  - DONE: done=1 for one cycle, busy=0 -> IDLE. win_row/win_col and I_out retain their last values.
- Frame size: (IMG-FIL+1)^2 = 676 windows per start.
- If out_ready is held high, the period is 11 cycles per window.
- img_rd_en / fil_rd_en are high only on issue cycles; they are never high at the same time.

Decomposition:
- window_pkg holds:
  - FSM state encoding (IDLE, LOAD_F, FETCH, HOLD, DONE).
  - Slot offset table: DR[9], DC[9].
  - Constants SLOT_POOL_COPY=4 and NSLOT=10.
- Sub-module window_addr_gen: row/col counters, wrap/last detection, img_addr computation from slot index. It is driven by advance, clear and slot strobes.

Test Plan:
- Filter memory k = 0x10+k; image pixel = addr mod 256; start pulse.
  - First out_valid I_out slots 0..9 = 0,1,28,2,29,30,56,57,58,29.
  - F_out taps = 0x10..0x18.
  - win_row=0, win_col=0.
  - out_valid occurs 20 cycles after start is sampled.
- out_ready held high.
  - Exactly 676 handshakes, then done for 1 cycle.
  - Last window (25,25) has slot 0 = 725 mod 256 = 0xD5 and slot 8 = 783 mod 256 = 0x0F.
  - Window (0,25) is followed by (1,0).
- At window (0,3), drop out_ready for 5 cycles.
  - I_out, win_col and out_valid stay unchanged.
  - No img_rd_en while stalled.
  - Handshake occurs on the cycle out_ready returns.
- Pulse start again during FETCH of window 5.
  - Ignored: no LOAD_F re-entry, window sequence uninterrupted.
- Assert rst_n=0 for 1 cycle mid-FETCH of window 10.
  - Next cycle: all outputs 0, state IDLE, no done pulse.
  - A new start then restarts from (0,0) with filter reload.
